// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package mem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RD_ADDR = 2'd2,
    RD_CAP  = 2'd3
  } state_e;

  // Byte distance between consecutive instruction words.
  localparam int ADDR_STRIDE = 4;

  // Width of the word-count port: it must represent MEMORY_DEPTH itself,
  // hence one bit more than the address-index width.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mem_loader_sum.sv
// Clearable accumulator that wraps modulo 2^DATA_WIDTH.
module mem_loader_sum #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] addend,
  output logic [DATA_WIDTH-1:0] sum
);

  // Clear has priority over accumulate so a new load always starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + addend;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Streams N words into instruction memory, reads them back and compares
// the modular checksums of written and read data.
//
// state   | meaning
// IDLE    | waiting for start_i; range-checks word_count_i
// LOAD    | accepting stream words, one registered write per handshake
// RD_ADDR | read address driven for the current index
// RD_CAP  | address held, read data accumulated into the read sum
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 64,
  parameter int DATA_WIDTH   = 32,
  parameter int BASE_ADDR    = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start_i,
  input  logic [cnt_width(MEMORY_DEPTH)-1:0]  word_count_i,
  input  logic [DATA_WIDTH-1:0]               s_data_i,
  input  logic                                s_valid_i,
  output logic                                s_ready_o,
  output logic                                mem_we_o,
  output logic [DATA_WIDTH-1:0]               mem_addr_o,
  output logic [DATA_WIDTH-1:0]               mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]               mem_rdata_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                error_o,
  output logic [DATA_WIDTH-1:0]               checksum_o
);

  localparam int CW = cnt_width(MEMORY_DEPTH);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_LOAD    = LOAD;
  localparam logic [1:0] S_RD_ADDR = RD_ADDR;
  localparam logic [1:0] S_RD_CAP  = RD_CAP;

  logic [1:0]            state;
  logic [CW-1:0]         index;
  logic [CW-1:0]         count;
  logic                  n_ok;
  logic                  clr;
  logic                  take;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wr_sum;
  logic [DATA_WIDTH-1:0] rd_sum;
  logic [DATA_WIDTH-1:0] rd_final;

  function automatic logic [DATA_WIDTH-1:0] word_addr(input logic [CW-1:0] i);
    return DATA_WIDTH'(BASE_ADDR) + DATA_WIDTH'(i) * DATA_WIDTH'(ADDR_STRIDE);
  endfunction

  assign n_ok      = (word_count_i != '0) && (word_count_i <= CW'(MEMORY_DEPTH));
  assign clr       = (state == S_IDLE) && start_i && n_ok;
  assign s_ready_o = (state == S_LOAD) && (index < count);
  assign take      = s_valid_i && s_ready_o;
  assign rd_en     = (state == S_RD_CAP);
  assign busy_o    = (state != S_IDLE);
  assign checksum_o = wr_sum;
  // Read sum including the word being captured this cycle.
  assign rd_final  = rd_sum + mem_rdata_i;

  mem_loader_sum #(.DATA_WIDTH(DATA_WIDTH)) u_wr_sum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .en     (take),
    .addend (s_data_i),
    .sum    (wr_sum)
  );

  mem_loader_sum #(.DATA_WIDTH(DATA_WIDTH)) u_rd_sum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .en     (rd_en),
    .addend (mem_rdata_i),
    .sum    (rd_sum)
  );

  // Sequencer, index counter and registered memory-port drivers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      index       <= '0;
      count       <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            if (word_count_i == '0) begin
              done_o <= 1'b1;
            end else if (!n_ok) begin
              error_o <= 1'b1;
            end else begin
              done_o  <= 1'b0;
              error_o <= 1'b0;
              count   <= word_count_i;
              index   <= '0;
              state   <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (take) begin
            mem_we_o    <= 1'b1;
            mem_addr_o  <= word_addr(index);
            mem_wdata_o <= s_data_i;
            index       <= index + CW'(1);
          end else if (mem_we_o && (index == count)) begin
            // Last write pulse is on the bus now; the address for the
            // first read must be in place for the whole RD_ADDR cycle.
            index      <= '0;
            mem_addr_o <= word_addr('0);
            state      <= S_RD_ADDR;
          end
        end
        S_RD_ADDR: begin
          state <= S_RD_CAP;
        end
        S_RD_CAP: begin
          if (index < count - CW'(1)) begin
            index      <= index + CW'(1);
            mem_addr_o <= word_addr(index + CW'(1));
            state      <= S_RD_ADDR;
          end else begin
            done_o  <= 1'b1;
            error_o <= (wr_sum != rd_final);
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Randomised self-checking bench for mem_loader with a behavioural memory.
module tb_mem_loader;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [6:0]  word_count_i = '0;
  logic [31:0] s_data_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [31:0] checksum_o;

  mem_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .word_count_i (word_count_i),
    .s_data_i     (s_data_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .checksum_o   (checksum_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int load_c0 = 0;

  logic [31:0] mem [DEPTH];
  logic [31:0] words [DEPTH];
  logic [31:0] rd_reg = '0;
  bit          rd_mode = 1'b0;
  int          flip_idx = -1;
  logic [5:0]  ra;

  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Memory model: write at the edge ending the we cycle, optional registered read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we_o) begin
      mem[mem_addr_o[7:2]] <= mem_wdata_o;
      wr_addr_q.push_back(int'(mem_addr_o));
      wr_data_q.push_back(mem_wdata_o);
      wr_cyc_q.push_back(cyc);
    end
    rd_reg <= mem[mem_addr_o[7:2]] ^ ((int'(mem_addr_o[7:2]) == flip_idx) ? 32'h1 : 32'h0);
  end

  always_comb begin
    ra = mem_addr_o[7:2];
    mem_rdata_i = rd_mode ? rd_reg
                          : (mem[ra] ^ ((int'(ra) == flip_idx) ? 32'h1 : 32'h0));
  end

  function automatic logic [31:0] ref_sum(input int n);
    logic [31:0] s = '0;
    for (int k = 0; k < n; k++) s = s + words[k];
    return s;
  endfunction

  // mode 0: unbroken stream, 1: valid on alternate cycles, 2: random gaps
  task automatic do_load(input int n, input int mode, input bit exp_err);
    int i = 0;
    int budget = 0;
    int done_cyc;
    bit v;
    logic [31:0] exp_sum = ref_sum(n);
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    @(negedge clk);
    start_i = 1'b1; word_count_i = 7'(n); load_c0 = cyc;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_cycle1", busy_o, 1);
    chk("ready_cycle1", s_ready_o, 1);
    while (i < n && budget < 2000) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = (budget % 2) == 0;
      else v = 1'($urandom_range(0, 1));
      s_valid_i = v;
      s_data_i = v ? words[i] : $urandom;
      if (v && s_ready_o) i++;
      @(negedge clk);
      budget++;
    end
    chk("stream_accepted", i, n);
    // Stream keeps offering junk; it must be refused.
    s_valid_i = 1'b1; s_data_i = $urandom;
    budget = 0;
    while (busy_o && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    done_cyc = cyc - load_c0;
    s_valid_i = 1'b0;
    chk("busy_timeout", busy_o, 0);
    chk("done", done_o, 1);
    chk("error", error_o, 32'(exp_err));
    chk("checksum", checksum_o, exp_sum);
    chk("n_writes", wr_addr_q.size(), n);
    for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
      chk("wr_addr", wr_addr_q[k], 4 * k);
      chk("wr_data", wr_data_q[k], words[k]);
      if (mode == 0) chk("wr_cycle", wr_cyc_q[k] - load_c0, k + 2);
    end
    if (mode == 0) chk("done_cycle", done_cyc, 3 * n + 2);
    for (int k = 0; k < n; k++) chk("mem_content", mem[k], words[k]);
  endtask

  initial begin
    int n0;
    for (int k = 0; k < DEPTH; k++) mem[k] = '0;

    repeat (3) @(negedge clk);
    chk("rst_flags", {28'd0, mem_we_o, busy_o, done_o, error_o}, 0);
    chk("rst_ready", s_ready_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_checksum", checksum_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back N=4
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h44444444;
    do_load(4, 0, 0);
    chk("checksum_aaaa", checksum_o, 32'hAAAAAAAA);

    // Same data with alternate-cycle valid
    do_load(4, 1, 0);

    // Readback corruption on word 2
    flip_idx = 2;
    do_load(4, 0, 1);
    flip_idx = -1;

    // Out-of-range count
    n0 = wr_addr_q.size();
    @(negedge clk);
    start_i = 1'b1; word_count_i = 7'd65;
    @(negedge clk);
    start_i = 1'b0;
    chk("oversize_error", error_o, 1);
    chk("oversize_busy", busy_o, 0);
    s_valid_i = 1'b1; s_data_i = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      chk("oversize_ready", s_ready_o, 0);
      @(negedge clk);
    end
    s_valid_i = 1'b0;
    chk("oversize_nowrite", wr_addr_q.size(), n0);

    // Reset in cycle 3 of an N=8 load
    for (int k = 0; k < 8; k++) words[k] = $urandom;
    @(negedge clk);
    start_i = 1'b1; word_count_i = 7'd8;
    @(negedge clk);
    start_i = 1'b0; s_valid_i = 1'b1; s_data_i = words[0];
    @(negedge clk);
    s_data_i = words[1];
    @(negedge clk);
    rst_n = 1'b0; s_data_i = words[2];
    @(negedge clk);
    chk("midrst_flags", {28'd0, mem_we_o, busy_o, done_o, error_o}, 0);
    chk("midrst_ready", s_ready_o, 0);
    chk("midrst_addr", mem_addr_o, 0);
    chk("midrst_checksum", checksum_o, 0);
    n0 = wr_addr_q.size();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    s_valid_i = 1'b0;
    chk("midrst_nowrite", wr_addr_q.size(), n0);

    // N=0 completes immediately
    @(negedge clk);
    start_i = 1'b1; word_count_i = 7'd0;
    @(negedge clk);
    start_i = 1'b0;
    chk("n0_done", done_o, 1);
    chk("n0_busy", busy_o, 0);

    do_load(2, 0, 0);

    // Full depth with wrapping checksum
    for (int k = 0; k < DEPTH; k++) words[k] = 32'hFFFFFFFF;
    do_load(64, 0, 0);
    chk("wrap_checksum", checksum_o, 32'hFFFFFFC0);
    if (wr_addr_q.size() == 64) chk("last_addr", wr_addr_q[63], 252);
    else chk("last_addr_present", wr_addr_q.size(), 64);

    // Random loads, random gaps, both read styles
    for (int t = 0; t < 6; t++) begin
      int n = $urandom_range(1, DEPTH);
      for (int k = 0; k < DEPTH; k++) words[k] = $urandom;
      rd_mode = 1'($urandom_range(0, 1));
      do_load(n, 2, 0);
    end
    rd_mode = 1'b1;
    do_load(DEPTH, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
